// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped countdown timer.
// Holds the FSM encoding, register offsets, CTRL bit positions and mode codes.
// Imported by timer_device; contains no logic.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } timer_state_e;

  // Word offsets selected by addr[3:2]
  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;

  // CTRL bit positions
  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  // Mode codes; 2 and 3 behave as one-shot
  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD  = 2'd1;

endpackage

// File: rtl/timer_device.sv
// Memory-mapped countdown timer (CTRL/PRESET/COUNT) with one-shot and auto-reload modes.
// Latency: reads are combinational; irq_flag rises max(PRESET,1)+2 edges after EN is written.
// Backpressure: none; single-cycle word writes are always accepted, misses are ignored.
module timer_device
  import timer_pkg::*;
#(
  parameter logic [31:0] BASE = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  timer_state_e state_q, state_d;
  logic [3:0]   ctrl_q, ctrl_d;
  logic [31:0]  preset_q, preset_d;
  logic [31:0]  count_q, count_d;
  logic         irq_flag_q, irq_flag_d;

  logic         sel;
  logic         hit;
  logic [1:0]   off;
  logic         en;
  logic [1:0]   mode;
  logic         unused_addr_bits;

  assign sel  = (addr[31:4] == BASE[31:4]);
  assign hit  = we && sel;
  assign off  = addr[3:2];
  assign en   = ctrl_q[CTRL_EN];
  assign mode = ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO];

  // Byte-lane bits of the address play no part in decoding
  assign unused_addr_bits = ^addr[1:0];

  // Next-state: FSM sequencing first, then bus writes, which win on collision
  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    irq_flag_d = irq_flag_q;

    case (state_q)
      ST_IDLE: begin
        if (en) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        // Loads the PRESET value registered before this edge
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!en) begin
          state_d = ST_IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          // COUNT of 0 or 1 both expire here, so COUNT never wraps
          count_d    = 32'd0;
          irq_flag_d = 1'b1;
          state_d    = ST_INT;
        end
      end
      ST_INT: begin
        if (mode == MODE_RELOAD) begin
          irq_flag_d = 1'b0;
        end else begin
          ctrl_d[CTRL_EN] = 1'b0;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (hit) begin
      case (off)
        OFF_CTRL: begin
          ctrl_d     = din[3:0];
          irq_flag_d = 1'b0;
        end
        OFF_PRESET: preset_d = din;
        default: ;
      endcase
    end
  end

  // State and register file, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ctrl_q     <= 4'd0;
      preset_q   <= 32'd0;
      count_q    <= 32'd0;
      irq_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
    end
  end

  // Combinational read mux; zero outside the decoded window and at the reserved offset
  always_comb begin
    dout = 32'd0;
    if (sel) begin
      case (off)
        OFF_CTRL:   dout = {28'd0, ctrl_q};
        OFF_PRESET: dout = preset_q;
        OFF_COUNT:  dout = count_q;
        default:    dout = 32'd0;
      endcase
    end
  end

  assign irq = irq_flag_q & ctrl_q[CTRL_IM];

endmodule

// File: tb/tb_timer_device.sv
// Directed bench for timer_device with a scoreboard of expected read/irq values.
// Stimulus issues bus writes and queues expected {irq, dout}; a monitor pops and compares.
// All inputs change 1 ns after the rising edge; samples are taken mid-cycle.
module tb_timer_device;

  localparam logic [31:0] BASE     = 32'h0000_7F00;
  localparam logic [31:0] A_CTRL   = 32'h0000_7F00;
  localparam logic [31:0] A_PRESET = 32'h0000_7F04;
  localparam logic [31:0] A_COUNT  = 32'h0000_7F08;
  localparam logic [31:0] A_RSV    = 32'h0000_7F0C;
  localparam logic [31:0] A_MISS   = 32'h0000_7F20;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  int checks;
  int failures;

  logic [32:0] exp_q[$];
  string       tag_q[$];
  event        chk_ev;

  timer_device #(.BASE(BASE)) dut (
    .clk  (clk),
    .reset(reset),
    .addr (addr),
    .we   (we),
    .din  (din),
    .dout (dout),
    .irq  (irq)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Monitor: pops one expectation per sample request and compares live outputs
  always @(chk_ev) begin
    logic [32:0] e;
    string       t;
    #1;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_underflow: sample with no queued expectation");
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      if ({irq, dout} !== e) begin
        failures++;
        $display("FAIL %s: got irq=%0b dout=%08h, want irq=%0b dout=%08h",
                 t, irq, dout, e[32], e[31:0]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a;
    din  = d;
    we   = 1'b1;
    @(posedge clk);
    #1;
    we  = 1'b0;
    din = 32'd0;
  endtask

  task automatic chk(input logic [31:0] a, input logic [31:0] ed, input logic ei,
                     input string t);
    addr = a;
    we   = 1'b0;
    exp_q.push_back({ei, ed});
    tag_q.push_back(t);
    ->chk_ev;
    #2;
  endtask

  // Mode-1 sequence, PRESET=2: samples after edges E4..E9
  logic [31:0] rl_cnt[6] = '{32'd0, 32'd0, 32'd0, 32'd2, 32'd1, 32'd0};
  logic        rl_irq[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    we       = 1'b0;
    addr     = A_CTRL;
    din      = 32'd0;
    #1;
    chk(A_CTRL,  32'd0, 1'b0, "reset_ctrl");
    chk(A_COUNT, 32'd0, 1'b0, "reset_count");
    step();
    reset = 1'b0;
    step();

    // One-shot, PRESET=3, IM=1: irq after E5, EN cleared after E6
    wr(A_PRESET, 32'd3);
    wr(A_CTRL, 32'h9);                       // E0
    chk(A_CTRL, 32'h9, 1'b0, "os_ctrl_e0");
    step();                                  // E1 LOAD
    chk(A_COUNT, 32'd0, 1'b0, "os_count_e1");
    step();                                  // E2
    chk(A_COUNT, 32'd3, 1'b0, "os_count_e2");
    step();                                  // E3
    step();                                  // E4
    chk(A_COUNT, 32'd1, 1'b0, "os_count_e4");
    step();                                  // E5 INT
    chk(A_CTRL, 32'h9, 1'b1, "os_irq_e5");
    step();                                  // E6 IDLE, EN cleared
    chk(A_CTRL,  32'h8, 1'b1, "os_ctrl_e6");
    chk(A_COUNT, 32'd0, 1'b1, "os_count_e6");
    step();
    chk(A_CTRL, 32'h8, 1'b1, "os_irq_held");
    wr(A_CTRL, 32'h8);
    chk(A_CTRL, 32'h8, 1'b0, "os_irq_cleared");

    // Reset asserted mid-count
    wr(A_PRESET, 32'd5);
    wr(A_CTRL, 32'h9);                       // E0
    step();
    step();                                  // E2
    chk(A_COUNT, 32'd5, 1'b0, "mid_count_pre");
    reset = 1'b1;
    chk(A_COUNT,  32'd0, 1'b0, "mid_rst_count");
    chk(A_CTRL,   32'd0, 1'b0, "mid_rst_ctrl");
    chk(A_PRESET, 32'd0, 1'b0, "mid_rst_preset");
    step();
    reset = 1'b0;
    step();

    // Auto-reload, PRESET=2: pulse after E4 and E9
    wr(A_PRESET, 32'd2);
    wr(A_CTRL, 32'hB);                       // E0
    step();
    step();                                  // E2
    chk(A_COUNT, 32'd2, 1'b0, "rl_count_e2");
    step();                                  // E3
    chk(A_COUNT, 32'd1, 1'b0, "rl_count_e3");
    for (int i = 0; i < 6; i++) begin
      step();                                // E4..E9
      chk(A_COUNT, rl_cnt[i], rl_irq[i], $sformatf("rl_e%0d", i + 4));
    end
    chk(A_CTRL, 32'hB, 1'b1, "rl_ctrl_kept");
    wr(A_CTRL, 32'h0);
    chk(A_CTRL, 32'h0, 1'b0, "rl_stop");

    // PRESET=0 expires after E3; with IM=0 irq stays low
    wr(A_PRESET, 32'd0);
    wr(A_CTRL, 32'h9);                       // E0
    step();
    step();                                  // E2
    chk(A_CTRL, 32'h9, 1'b0, "p0_e2");
    step();                                  // E3
    chk(A_CTRL, 32'h9, 1'b1, "p0_irq_e3");
    wr(A_CTRL, 32'h0);
    wr(A_CTRL, 32'h1);                       // E0, IM=0
    step();
    step();
    step();                                  // E3 INT
    chk(A_CTRL, 32'h1, 1'b0, "p0_masked_e3");
    step();                                  // E4 EN cleared
    chk(A_CTRL, 32'h0, 1'b0, "p0_masked_e4");
    wr(A_CTRL, 32'h0);

    // Reload with PRESET rewritten mid-count; COUNT writes ignored
    wr(A_PRESET, 32'd4);
    wr(A_CTRL, 32'hB);                       // E0
    step();
    step();                                  // E2
    chk(A_COUNT, 32'd4, 1'b0, "pr_count_e2");
    wr(A_PRESET, 32'd10);                    // E3
    chk(A_PRESET, 32'd10, 1'b0, "pr_preset_new");
    chk(A_COUNT,  32'd3,  1'b0, "pr_count_e3");
    wr(A_COUNT, 32'h55);                     // E4
    chk(A_COUNT, 32'd2, 1'b0, "pr_count_ro");
    step();                                  // E5
    step();                                  // E6 INT
    chk(A_COUNT, 32'd0, 1'b1, "pr_irq_e6");
    step();
    step();
    step();                                  // E9 new period
    chk(A_COUNT, 32'd10, 1'b0, "pr_count_e9");
    step();                                  // E10
    chk(A_COUNT, 32'd9, 1'b0, "pr_count_e10");
    wr(A_CTRL, 32'h0);                       // E11
    chk(A_COUNT, 32'd8, 1'b0, "pr_count_e11");
    step();
    step();
    chk(A_COUNT, 32'd8, 1'b0, "pr_count_frozen");

    // Writes outside the decoded registers
    wr(A_RSV,  32'hFFFF_FFFF);
    wr(A_MISS, 32'h0000_000B);
    chk(A_MISS,   32'd0,  1'b0, "miss_dout");
    chk(A_RSV,    32'd0,  1'b0, "rsv_dout");
    chk(A_CTRL,   32'd0,  1'b0, "miss_ctrl");
    chk(A_PRESET, 32'd10, 1'b0, "miss_preset");

    // CTRL write on the one-shot INT edge wins and restarts in reload mode
    wr(A_PRESET, 32'd1);
    wr(A_CTRL, 32'h9);                       // E0
    step();
    step();
    step();                                  // E3 INT
    chk(A_CTRL, 32'h9, 1'b1, "col_irq_e3");
    wr(A_CTRL, 32'hB);                       // E4 collides with INT
    chk(A_CTRL, 32'hB, 1'b0, "col_ctrl_wins");
    step();
    step();
    step();                                  // E7
    chk(A_CTRL, 32'hB, 1'b1, "col_restart_irq");
    step();                                  // E8
    chk(A_CTRL, 32'hB, 1'b0, "col_pulse_end");
    wr(A_CTRL, 32'h0);

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/timer_device.md
Name: timer_device

Overview:
- Memory-mapped countdown timer on the CPU data bus at 0x0000_7F00–0x0000_7F0B, downstream of the core's m_data_addr / m_data_wdata / m_data_byteen stores.
- Its irq output drives the core's interrupt input, which is the interrupt source currently stubbed by the system bench.
- Supports one-shot mode (mode 0) and auto-reload mode (mode 1), both with maskable interrupt.

Parameters:
- BASE, 32'h0000_7F00, base byte address; the block decodes addr[31:4] == BASE[31:4].

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- addr  input  32  byte address from the core (bits [1:0] ignored).
- we  input  1  write strobe; the core asserts it only for word stores (byteen == 4'hF) that hit this device.
- din  input  32  write data.
- dout  output  32  combinational read data for addr.
- irq  output  1  interrupt request to the core: irq_flag & CTRL.IM.

Behaviour:
- Registers, selected by offset addr[3:2]:
  - 0 CTRL: bit0 EN, bits[2:1] MODE, bit3 IM; bits[31:4] are hardwired 0.
  - 1 PRESET: 32-bit, read/write.
  - 2 COUNT: 32-bit, read-only; writes are ignored.
  - 3: reserved; reads return 0, writes are ignored.
- hit = we && addr[31:4] == BASE[31:4]. Addresses that miss do not affect the block.
- dout = selected register when addr[31:4] == BASE[31:4], otherwise 0. No read latency.
- Reset (async): CTRL=0, PRESET=0, COUNT=0, state=IDLE, irq_flag=0. irq=0 and dout=0 while reset is held.
- FSM states: IDLE, LOAD, CNT, INT.
  - IDLE: if EN → LOAD.
  - LOAD: COUNT ← PRESET → CNT.
  - CNT:
    - if !EN → IDLE; COUNT holds.
    - else if COUNT > 1: COUNT ← COUNT−1.
    - else (COUNT is 0 or 1): COUNT ← 0, irq_flag ← 1 → INT.
  - INT, MODE==1: irq_flag ← 0 → IDLE. EN stays set, so the timer reloads.
  - INT, any other MODE: EN ← 0, irq_flag held → IDLE. MODE 2/3 behave as MODE 0.
- Latency, with the CTRL write of EN=1 at edge E0 and PRESET=N:
  - LOAD at E1, COUNT=N after E2.
  - irq_flag rises after edge E(max(N,1)+2).
- Mode 1 timing: irq_flag is high for exactly one cycle. The period is max(N,1)+3 cycles from one irq rise to the next.
- Mode 0: irq_flag stays high until cleared by software. Any CTRL write clears irq_flag.
- Simultaneous events:
  - A CTRL write on the same edge that INT clears EN: the written value wins, and irq_flag is cleared.
  - A CTRL write with EN=0 while in CNT: the FSM sees EN=0 at the next edge → IDLE; COUNT freezes.
  - PRESET writes while counting do not affect COUNT until the next LOAD.
  - A PRESET write during LOAD: LOAD loads the old PRESET; the new value applies next period.
- COUNT uses unsigned 32-bit arithmetic and never wraps below 0.
- Changing IM masks or unmasks irq combinationally; irq_flag is not affected.

Decomposition:
- Shared package timer_pkg:
  - FSM state encoding: 2-bit enum, IDLE=0, LOAD=1, CNT=2, INT=3.
  - Register offsets: CTRL=0, PRESET=1, COUNT=2.
  - CTRL bit positions: EN=0, MODE=2:1, IM=3.
  - Mode codes: ONESHOT=0, RELOAD=1.
- Single module, with no sub-module; the register file and FSM are too small to split.

Test Plan:
- Reset assertion mid-count (COUNT=5, state CNT) → next sample shows COUNT=0, irq=0, CTRL reads 0, without waiting for a clk edge.
- PRESET=3, CTRL=0x9 (EN, mode 0, IM) written at E0 → irq rises after E5, remains high, CTRL reads 0x8 (EN cleared), COUNT reads 0. A subsequent write of CTRL=0x8 drops irq at the next edge.
- PRESET=2, CTRL=0xB (mode 1, IM) → irq is a 1-cycle pulse every 5 cycles, first after E4. COUNT reads 2, 1, 0 in sequence between pulses.
- PRESET=0, CTRL=0x9 → irq after E3. Same test with CTRL=0x1 (IM=0) → irq stays 0 while the INT state is still reached and CTRL reads 0.
- Mode 1, PRESET=4, rewrite PRESET=10 while in CNT → the current period completes with 4; the next period counts from 10. Write COUNT=0x55 → ignored, reads unchanged.
- Write to 0x7F0C or 0x7F20 → no register changes, dout=0. A CTRL write on the INT edge in mode 0 with din=0xB → CTRL=0xB, irq_flag=0, timer restarts.
